// File: rtl/accumulator.sv
// rtl/accumulator.sv - 4-bit accumulator register on a shared tri-state data bus
// Optional increment operation on enable 2'b11 is built only when ACC_INC_EN is defined.
module accumulator #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  inout  wire  [WIDTH-1:0] data_bus,
  input  logic [1:0]       accumulator_enable,
  output logic [WIDTH-1:0] A,
  output logic             carry
);

  localparam logic [1:0] EN_HOLD  = 2'b00;
  localparam logic [1:0] EN_LOAD  = 2'b01;
  localparam logic [1:0] EN_DRIVE = 2'b10;

  logic drive_bus;

  // Bus drive is combinational from enable/reset so release happens without a clock.
  assign drive_bus = (accumulator_enable == EN_DRIVE) && !reset;
  assign data_bus  = drive_bus ? A : {WIDTH{1'bz}};

`ifdef ACC_INC_EN
  localparam logic [1:0] EN_INC = 2'b11;

  logic [WIDTH:0] inc_sum;

  assign inc_sum = {1'b0, A} + {{WIDTH{1'b0}}, 1'b1};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      A     <= '0;
      carry <= 1'b0;
    end else begin
      case (accumulator_enable)
        EN_LOAD: begin
          A     <= data_bus;
          carry <= 1'b0;
        end
        EN_INC: begin
          A     <= inc_sum[WIDTH-1:0];
          carry <= inc_sum[WIDTH];
        end
        default: begin
          A     <= A;
          carry <= carry;
        end
      endcase
    end
  end
`else
  assign carry = 1'b0;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      A <= '0;
    end else if (accumulator_enable == EN_LOAD) begin
      A <= data_bus;
    end else begin
      A <= A;
    end
  end
`endif

endmodule

// File: tb/tb_accumulator.sv
// tb/tb_accumulator.sv - randomized self-checking bench for accumulator against a behavioural model
// The bus carries a pull-up so a released bus reads all ones.
module tb_accumulator;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [1:0] accumulator_enable = 2'b00;
  logic [3:0] A;
  logic       carry;
  logic       drv_en = 1'b0;
  logic [3:0] drv_val = 4'h0;
  tri1  [3:0] data_bus;

  int vectors = 0;
  int miscompares = 0;
  bit model_on = 1'b0;

  logic [3:0] m_a = 4'h0;
  logic       m_c = 1'b0;
  logic [3:0] last_loaded = 4'h0;

  assign data_bus = drv_en ? drv_val : 4'bzzzz;

  accumulator #(.WIDTH(4)) dut (
    .clk(clk),
    .reset(reset),
    .data_bus(data_bus),
    .accumulator_enable(accumulator_enable),
    .A(A),
    .carry(carry)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: A/carry follow the operation sampled at each rising edge; reset clears at once.
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_a = 4'h0;
      m_c = 1'b0;
    end else begin
      if (accumulator_enable == 2'b01) begin
        m_a = drv_val;
        m_c = 1'b0;
      end
`ifdef ACC_INC_EN
      else if (accumulator_enable == 2'b11) begin
        m_c = (m_a == 4'hF);
        m_a = 4'((int'(m_a) + 1) % 16);
      end
`endif
    end
  end

  always @(negedge clk) begin
    if (model_on) begin
      chk("model_A", A, m_a);
      chk("model_carry", carry, m_c);
      if (drv_en)
        chk("model_bus_tb", data_bus, drv_val);
      else if (!reset && accumulator_enable == 2'b10)
        chk("model_bus_drive", data_bus, m_a);
      else
        chk("model_bus_release", data_bus, 4'hF);
    end
  end

  task automatic step(input logic [1:0] en, input logic de, input logic [3:0] dv);
    @(negedge clk);
    #2;
    accumulator_enable = en;
    drv_en = de;
    drv_val = dv;
    if (en == 2'b01 && !reset) last_loaded = dv;
  endtask

  task automatic after_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input logic [3:0] v);
    step(2'b01, 1'b1, v);
    after_edge();
  endtask

  initial begin
    logic [1:0] en;
    logic [3:0] v;

    repeat (2) @(posedge clk);
    #1;
    chk("reset_A", A, 4'h0);
    chk("reset_carry", carry, 1'b0);
    chk("reset_bus", data_bus, 4'hF);
    @(negedge clk);
    reset = 1'b0;
    model_on = 1'b1;

    load(4'hA);
    chk("load_A", A, 4'hA);
    step(2'b00, 1'b1, 4'h3);
    after_edge();
    chk("hold_A", A, 4'hA);

    load(4'h9);
    chk("load9_A", A, 4'h9);
    step(2'b00, 1'b0, 4'h0);
    reset = 1'b1;
    #1;
    chk("async_reset_A", A, 4'h0);
    chk("async_reset_carry", carry, 1'b0);
    chk("async_reset_bus", data_bus, 4'hF);
    @(negedge clk);
    #1 reset = 1'b0;

    load(4'h5);
    step(2'b10, 1'b0, 4'h0);
    #1;
    chk("drive_bus", data_bus, 4'h5);
    accumulator_enable = 2'b00;
    #1;
    chk("release_bus", data_bus, 4'hF);

    load(4'hE);
    step(2'b11, 1'b0, 4'h0);
    after_edge();
`ifdef ACC_INC_EN
    chk("inc1_A", A, 4'hF);
    chk("inc1_carry", carry, 1'b0);
`else
    chk("inc1_A", A, 4'hE);
    chk("inc1_carry", carry, 1'b0);
`endif
    after_edge();
`ifdef ACC_INC_EN
    chk("inc2_A", A, 4'h0);
    chk("inc2_carry", carry, 1'b1);
`else
    chk("inc2_A", A, 4'hE);
    chk("inc2_carry", carry, 1'b0);
`endif
    step(2'b10, 1'b0, 4'h0);
    after_edge();
`ifdef ACC_INC_EN
    chk("carry_hold_drive", carry, 1'b1);
`else
    chk("carry_hold_drive", carry, 1'b0);
`endif

    step(2'b01, 1'b1, 4'h7);
    reset = 1'b1;
    after_edge();
    chk("reset_load_A", A, 4'h0);
    after_edge();
    chk("reset_load_A2", A, 4'h0);
    step(2'b00, 1'b0, 4'h0);
    reset = 1'b0;

    for (int r = 0; r < 3; r++) begin
      for (int e = 0; e < 4; e++) begin
        for (int k = 0; k < 5; k++) begin
          en = 2'(e);
          v = 4'($urandom_range(0, 15));
          step(en, en != 2'b10, v);
        end
      end
      after_edge();
`ifdef ACC_INC_EN
      chk("sweep_A", A, 4'((int'(last_loaded) + 5) % 16));
`else
      chk("sweep_A", A, last_loaded);
`endif
    end

    for (int i = 0; i < 400; i++) begin
      en = 2'($urandom_range(0, 3));
      v = 4'($urandom_range(0, 15));
      step(en, (en != 2'b10) && ($urandom_range(0, 3) != 0 || en == 2'b01), v);
      if ($urandom_range(0, 29) == 0) begin
        #1 reset = 1'b1;
        #1;
        chk("rand_async_reset_A", A, 4'h0);
        @(negedge clk);
        #1 reset = 1'b0;
      end
    end

    step(2'b00, 1'b0, 4'h0);
    after_edge();
    model_on = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
